demux_sched_2to1: RTL and testbench

Packet-aware scheduler that shares one input stream between two consumers. It sits in front of the 2-to-1 demux datapath. Each packet's destination is chosen by round-robin or by an explicit per-packet select. The channel is then locked until the packet's last beat, and every beat is registered into a one-entry holding slot per output with valid/ready backpressure. The block also counts completed packets per channel.

---
 rtl/demux_pkg.sv | 13 +
 rtl/demux_out_slot.sv | 30 +++
 rtl/demux_sched_2to1.sv | 105 ++++++++++
 tb/tb_demux_sched_2to1.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types and constants for the packet-aware 2-to-1 demux scheduler.
package demux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK1 = 2'd1,
        LOCK2 = 2'd2
    } state_t;

    localparam logic DEST_OUT1 = 1'b0;
    localparam logic DEST_OUT2 = 1'b1;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry valid/ready holding register; payload stays stable while stalled.
module demux_out_slot #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic         free
);

    // A slot can take a new beat in the same cycle its current one is popped.
    assign free = !valid || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_sched_2to1.sv
// Packet scheduler: picks a destination per packet (round-robin or explicit),
// locks it until the last beat, and counts completed packets per channel.
module demux_sched_2to1
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_dest,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_last,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_last,
    output logic [CNT_W-1:0] pkt_cnt1,
    output logic [CNT_W-1:0] pkt_cnt2,
    output logic             busy
);

    state_t state, state_nxt;
    logic   rr;
    logic   target;
    logic   free1, free2;
    logic   accept;
    logic   load1, load2;

    // mode/in_dest only matter when choosing a new packet's destination.
    always_comb begin
        target = DEST_OUT1;
        case (state)
            IDLE:    target = mode ? in_dest : rr;
            LOCK1:   target = DEST_OUT1;
            LOCK2:   target = DEST_OUT2;
            default: target = DEST_OUT1;
        endcase
    end

    assign in_ready = (target == DEST_OUT2) ? free2 : free1;
    assign accept   = in_valid && in_ready;
    assign load1    = accept && (target == DEST_OUT1);
    assign load2    = accept && (target == DEST_OUT2);

    always_comb begin
        state_nxt = state;
        if (accept) begin
            case (state)
                IDLE:    if (!in_last) state_nxt = (target == DEST_OUT2) ? LOCK2 : LOCK1;
                LOCK1,
                LOCK2:   if (in_last) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr       <= DEST_OUT1;
            pkt_cnt1 <= '0;
            pkt_cnt2 <= '0;
        end else begin
            state <= state_nxt;
            if (accept && in_last) begin
                rr <= ~target;
                if (target == DEST_OUT2) pkt_cnt2 <= pkt_cnt2 + CNT_W'(1);
                else                     pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
            end
        end
    end

    demux_out_slot #(.W(WIDTH + 1)) u_slot1 (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load1),
        .din   ({in_last, in_data}),
        .ready (out1_ready),
        .valid (out1_valid),
        .dout  ({out1_last, out1_data}),
        .free  (free1)
    );

    demux_out_slot #(.W(WIDTH + 1)) u_slot2 (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load2),
        .din   ({in_last, in_data}),
        .ready (out2_ready),
        .valid (out2_valid),
        .dout  ({out2_last, out2_data}),
        .free  (free2)
    );

    assign busy = (state != IDLE) || out1_valid || out2_valid;

endmodule

// File: tb/tb_demux_sched_2to1.sv
// Directed bench for demux_sched_2to1 with hand-computed expectations.
module tb_demux_sched_2to1;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             mode = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_last = 1'b0;
    logic             in_dest = 1'b0;
    logic             out1_valid, out2_valid;
    logic             out1_ready = 1'b1;
    logic             out2_ready = 1'b1;
    logic [WIDTH-1:0] out1_data, out2_data;
    logic             out1_last, out2_last;
    logic [CNT_W-1:0] pkt_cnt1, pkt_cnt2;
    logic             busy;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    demux_sched_2to1 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_dest    (in_dest),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out1_last  (out1_last),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .out2_data  (out2_data),
        .out2_last  (out2_last),
        .pkt_cnt1   (pkt_cnt1),
        .pkt_cnt2   (pkt_cnt2),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".o1v"}, 32'(out1_valid), 32'd0);
        chk({tag, ".o2v"}, 32'(out2_valid), 32'd0);
        chk({tag, ".o1d"}, 32'(out1_data), 32'd0);
        chk({tag, ".o2d"}, 32'(out2_data), 32'd0);
        chk({tag, ".o1l"}, 32'(out1_last), 32'd0);
        chk({tag, ".o2l"}, 32'(out2_last), 32'd0);
        chk({tag, ".c1"}, 32'(pkt_cnt1), 32'd0);
        chk({tag, ".c2"}, 32'(pkt_cnt2), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present one beat at the negedge, expect it accepted that cycle and
    // landed in channel ch after the following posedge.
    task automatic beat(input string tag, input logic [7:0] d, input logic l,
                        input logic ds, input logic m, input logic ch);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_dest  = ds;
        mode     = m;
        #1;
        chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        if (ch) begin
            chk({tag, ".o2v"}, 32'(out2_valid), 32'd1);
            chk({tag, ".o2d"}, 32'(out2_data), 32'(d));
            chk({tag, ".o2l"}, 32'(out2_last), 32'(l));
        end else begin
            chk({tag, ".o1v"}, 32'(out1_valid), 32'd1);
            chk({tag, ".o1d"}, 32'(out1_data), 32'(d));
            chk({tag, ".o1l"}, 32'(out1_last), 32'(l));
        end
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    logic [7:0] rr_data [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    logic       rr_last [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       rr_ch   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [CNT_W-1:0] wrap_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        // Reset state
        #12;
        chk_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);

        // Round-robin: packets of length 3, 1, 2
        for (int i = 0; i < 6; i++)
            beat($sformatf("rr%0d", i), rr_data[i], rr_last[i], 1'b0, 1'b0, rr_ch[i]);
        chk("rr.cnt1", 32'(pkt_cnt1), 32'd2);
        chk("rr.cnt2", 32'(pkt_cnt2), 32'd1);
        idle_in();
        @(posedge clk);
        #1;
        chk("rr.drained", 32'(busy), 32'd0);

        // Explicit mode; mode/in_dest changes mid-packet are ignored
        do_reset();
        beat("ex0", 8'h20, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("ex.busy", 32'(busy), 32'd1);
        beat("ex1", 8'h21, 1'b0, 1'b0, 1'b0, 1'b1);
        beat("ex2", 8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
        beat("ex3", 8'h23, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("ex.cnt2", 32'(pkt_cnt2), 32'd1);
        beat("ex4", 8'h24, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("ex.cnt1", 32'(pkt_cnt1), 32'd1);
        idle_in();

        // Backpressure on the locked channel while out2 drains
        do_reset();
        out2_ready = 1'b0;
        beat("bp0", 8'h30, 1'b1, 1'b1, 1'b1, 1'b1);
        out1_ready = 1'b0;
        beat("bp1", 8'h31, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            out2_ready = 1'b1;
            in_valid   = 1'b1;
            in_data    = 8'h32;
            in_last    = 1'b0;
            mode       = 1'b1;
            in_dest    = 1'b1;
            #1;
            chk($sformatf("bp.stall%0d.rdy", i), 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("bp.stall%0d.o1v", i), 32'(out1_valid), 32'd1);
            chk($sformatf("bp.stall%0d.o1d", i), 32'(out1_data), 32'h31);
            chk($sformatf("bp.stall%0d.o2v", i), 32'(out2_valid), 32'd0);
        end
        out1_ready = 1'b1;
        beat("bp2", 8'h32, 1'b0, 1'b1, 1'b1, 1'b0);
        beat("bp3", 8'h33, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("bp.cnt1", 32'(pkt_cnt1), 32'd1);
        chk("bp.cnt2", 32'(pkt_cnt2), 32'd1);
        idle_in();
        @(posedge clk);
        #1;
        chk("bp.o1v_end", 32'(out1_valid), 32'd0);

        // Counter wrap with CNT_W = 2
        do_reset();
        for (int i = 0; i < 5; i++) begin
            beat($sformatf("wr%0d", i), 8'(8'h50 + i), 1'b1, 1'b0, 1'b1, 1'b0);
            chk($sformatf("wr%0d.cnt1", i), 32'(pkt_cnt1), 32'(wrap_exp[i]));
        end
        chk("wr.cnt2", 32'(pkt_cnt2), 32'd0);
        idle_in();

        // Reset in the middle of a packet to out2
        do_reset();
        beat("mr0", 8'h40, 1'b0, 1'b1, 1'b1, 1'b1);
        beat("mr1", 8'h41, 1'b0, 1'b1, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk_all_zero("mr");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mr.in_ready", 32'(in_ready), 32'd1);
        beat("mr2", 8'h42, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("mr.o2v", 32'(out2_valid), 32'd0);
        idle_in();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
